// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_ctrl_pkg: FSM state type and op encodings for mem_access_ctrl.         |
// | Macro MEM_CTRL_CLEAR_EN adds the CLEAR state.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
`ifdef MEM_CTRL_CLEAR_EN
    ST_READ  = 2'd2,
    ST_CLEAR = 2'd3
`else
    ST_READ  = 2'd2
`endif
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cell_sel_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cell_sel_decoder: index + enable to one-hot cell enable; 0 if out of range.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cell_sel_decoder #(
  parameter int NUM_CELLS = 8,
  parameter int IDX_W     = 4
) (
  input  logic                 i_en,
  input  logic [IDX_W-1:0]     i_idx,
  output logic [NUM_CELLS-1:0] o_ce
);

  // An index at or beyond NUM_CELLS matches no bit, so the result is all zero.
  generate
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_ce
      assign o_ce[i] = i_en && (i_idx == IDX_W'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_ctrl: single-request controller for a bank of shared-bus cells. |
// | Macro MEM_CTRL_CLEAR_EN enables a zero-fill sweep after reset.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_ctrl #(
  parameter int NUM_CELLS = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic [NUM_CELLS-1:0] cell_ce,
  output logic                 cell_we,
  output logic [DATA_W-1:0]    cell_di,
  input  logic [DATA_W-1:0]    cell_do
);

  import mem_ctrl_pkg::*;

  // One extra bit so the select index can also hold NUM_CELLS itself.
  localparam int SEL_W = ADDR_W + 1;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic [NUM_CELLS-1:0]  cell_ce_q, cell_ce_d;
  logic                  cell_we_q, cell_we_d;
  logic [DATA_W-1:0]     cell_di_q, cell_di_d;

  logic                  accept;
  logic                  in_range;
  logic                  sel_en;
  logic [SEL_W-1:0]      sel_idx;

`ifdef MEM_CTRL_CLEAR_EN
  logic [SEL_W-1:0]      clr_idx_q, clr_idx_d;
`endif

  assign accept   = req_valid & req_ready_q;
  assign in_range = {1'b0, req_addr} < SEL_W'(NUM_CELLS);

  cell_sel_decoder #(
    .NUM_CELLS (NUM_CELLS),
    .IDX_W     (SEL_W)
  ) u_cell_sel_decoder (
    .i_en  (sel_en),
    .i_idx (sel_idx),
    .o_ce  (cell_ce_d)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    cell_we_d    = 1'b0;
    cell_di_d    = '0;
    sel_en       = 1'b0;
    sel_idx      = {1'b0, req_addr};
`ifdef MEM_CTRL_CLEAR_EN
    clr_idx_d    = clr_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          if (in_range) begin
            sel_en      = 1'b1;
            req_ready_d = 1'b0;
            if (req_wr == OP_WR) begin
              state_d   = ST_WRITE;
              cell_we_d = 1'b1;
              cell_di_d = req_wdata;
            end else begin
              state_d   = ST_READ;
            end
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b1;
      end
      ST_READ: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b1;
        resp_rdata_d = cell_do;
      end
`ifdef MEM_CTRL_CLEAR_EN
      ST_CLEAR: begin
        if (clr_idx_q == SEL_W'(NUM_CELLS)) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          sel_en    = 1'b1;
          sel_idx   = clr_idx_q;
          cell_we_d = 1'b1;
          clr_idx_d = clr_idx_q + SEL_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MEM_CTRL_CLEAR_EN
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
`else
      state_q      <= ST_IDLE;
`endif
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      cell_ce_q    <= '0;
      cell_we_q    <= 1'b0;
      cell_di_q    <= '0;
    end else begin
`ifdef MEM_CTRL_CLEAR_EN
      clr_idx_q    <= clr_idx_d;
`endif
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cell_ce_q    <= cell_ce_d;
      cell_we_q    <= cell_we_d;
      cell_di_q    <= cell_di_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign cell_ce    = cell_ce_q;
  assign cell_we    = cell_we_q;
  assign cell_di    = cell_di_q;

endmodule
`default_nettype wire
